// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEPTH_DEF = 2048;
    localparam int unsigned AW_DEF    = 32;
    localparam int unsigned DW_DEF    = 32;

    // Requester index: 0 = CPU load/store, 1 = DMA/debug
    typedef logic [0:0] port_idx_t;

    // One-cycle response record carried from issue to completion
    typedef struct packed {
        logic      valid;  // in-range read issued, data returns next cycle
        port_idx_t owner;  // port that issued the access
        logic      err;    // out-of-range access accepted and dropped
    } resp_t;

endpackage

// File: rtl/dmem_arb_if.sv
// Requester-side bus of the data-memory arbiter (one instance per port).
interface dmem_arb_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// Winner select between the two requesters.
// DMEM_ARB_RR_EN: defined = round-robin on last_owner, undefined = port 0 fixed priority.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic      req0,
    input  logic      req1,
`ifdef DMEM_ARB_RR_EN
    input  port_idx_t last_owner,
`endif
    output logic      any_c,
    output port_idx_t sel_c
);

    // A lone requester always wins; a tie is resolved by the configured policy
    always_comb begin
        any_c = req0 | req1;
        sel_c = port_idx_t'(0);
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
            sel_c = ~last_owner;
`else
            sel_c = port_idx_t'(0);
`endif
        end else if (req1) begin
            sel_c = port_idx_t'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port synchronous data memory.
// One access issued per cycle, read data returned one cycle after issue.
// DMEM_ARB_RR_EN: defined = round-robin arbitration, undefined = port 0 fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dmem_arb_if.slave                m0,
    dmem_arb_if.slave                m1,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DW-1:0]            mem_wdata,
    output logic                     mem_rd,
    output logic                     mem_wr,
    input  logic [DW-1:0]            mem_rdata
);

    localparam int unsigned MAW = $clog2(DEPTH);

    logic            any_c;
    port_idx_t       sel_c;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            in_range;
    logic [MAW-1:0]  addr_q;
    logic [DW-1:0]   wdata_q;
    resp_t           resp_d;
    resp_t           resp_q;

`ifdef DMEM_ARB_RR_EN
    port_idx_t       last_owner;
`endif

    dmem_arb_pick u_pick (
        .req0       (m0.req),
        .req1       (m1.req),
`ifdef DMEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .any_c      (any_c),
        .sel_c      (sel_c)
    );

    // Route the winning request onto the shared access path
    always_comb begin
        sel_we    = m0.we;
        sel_addr  = m0.addr;
        sel_wdata = m0.wdata;
        if (sel_c == port_idx_t'(1)) begin
            sel_we    = m1.we;
            sel_addr  = m1.addr;
            sel_wdata = m1.wdata;
        end
    end

    // Grants, memory strobes and the response record for this cycle's issue
    always_comb begin
        in_range     = sel_addr < AW'(DEPTH);
        m0.gnt       = any_c && (sel_c == port_idx_t'(0));
        m1.gnt       = any_c && (sel_c == port_idx_t'(1));
        mem_rd       = any_c && !sel_we && in_range;
        mem_wr       = any_c && sel_we && in_range;
        mem_addr     = any_c ? MAW'(sel_addr) : addr_q;
        mem_wdata    = any_c ? sel_wdata : wdata_q;
        resp_d       = '0;
        resp_d.valid = any_c && !sel_we && in_range;
        resp_d.owner = sel_c;
        resp_d.err   = any_c && !in_range;
    end

    // Memory address/data hold their last issued value while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (any_c) begin
            addr_q  <= MAW'(sel_addr);
            wdata_q <= sel_wdata;
        end
    end

    // Response pipeline stage: completes the access issued last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Reset to port 1 so port 0 wins the first tie; moves only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= port_idx_t'(1);
        end else if (any_c) begin
            last_owner <= sel_c;
        end
    end
`endif

    // Steer the returning read data and error pulse to the owning port
    always_comb begin
        m0.rvalid = resp_q.valid && (resp_q.owner == port_idx_t'(0));
        m1.rvalid = resp_q.valid && (resp_q.owner == port_idx_t'(1));
        m0.err    = resp_q.err && (resp_q.owner == port_idx_t'(0));
        m1.err    = resp_q.err && (resp_q.owner == port_idx_t'(1));
        m0.rdata  = m0.rvalid ? mem_rdata : '0;
        m1.rdata  = m1.rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 2048x32 synchronous memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:2047];
    logic        init_done = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arb_if m0_if ();
    dmem_arb_if m1_if ();

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory; preloaded with A000_0000 | index before use
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem_rdata <= '0;
        end else begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            if (mem_rd) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
        m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic eg0;
    logic prev_g0;
    logic prev_g1;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 init_done = 1'b1;
        #2;
        // Reset state
        check("rst_gnt0",   32'(m0_if.gnt),    32'd0);
        check("rst_gnt1",   32'(m1_if.gnt),    32'd0);
        check("rst_rvalid0", 32'(m0_if.rvalid), 32'd0);
        check("rst_rvalid1", 32'(m1_if.rvalid), 32'd0);
        check("rst_err0",   32'(m0_if.err),    32'd0);
        check("rst_err1",   32'(m1_if.err),    32'd0);
        check("rst_rdata0", m0_if.rdata,       32'd0);
        check("rst_rdata1", m1_if.rdata,       32'd0);
        check("rst_mem_rd", 32'(mem_rd),       32'd0);
        check("rst_mem_wr", 32'(mem_wr),       32'd0);
        check("rst_mem_addr", 32'(mem_addr),   32'd0);
        check("rst_mem_wdata", mem_wdata,      32'd0);

        // Both ports read continuously: addr 10 on port 0, addr 20 on port 1
        tick();
        rst_n = 1'b1;
        drive(1, 0, 10, 0, 1, 0, 20, 0);
        prev_g0 = 1'b0;
        prev_g1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
`ifdef DMEM_ARB_RR_EN
            eg0 = (i % 2) == 0;
`else
            eg0 = 1'b1;
`endif
            check("both_gnt0",   32'(m0_if.gnt),    32'(eg0));
            check("both_gnt1",   32'(m1_if.gnt),    32'(!eg0));
            check("both_mem_rd", 32'(mem_rd),       32'd1);
            check("both_addr",   32'(mem_addr),     eg0 ? 32'd10 : 32'd20);
            check("both_rvalid0", 32'(m0_if.rvalid), 32'(prev_g0));
            check("both_rvalid1", 32'(m1_if.rvalid), 32'(prev_g1));
            check("both_rdata0", m0_if.rdata, prev_g0 ? 32'hA000_000A : 32'd0);
            check("both_rdata1", m1_if.rdata, prev_g1 ? 32'hA000_0014 : 32'd0);
            prev_g0 = eg0;
            prev_g1 = !eg0;
            tick();
        end

        // Port 0 drops: port 1 is granted in the same cycle
        drive(0, 0, 0, 0, 1, 0, 20, 0);
        #2;
        check("solo1_gnt1", 32'(m1_if.gnt), 32'd1);
        check("solo1_gnt0", 32'(m0_if.gnt), 32'd0);
        check("solo1_addr", 32'(mem_addr),  32'd20);
        check("solo1_rvalid0", 32'(m0_if.rvalid), 32'(prev_g0));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("solo1_rvalid1", 32'(m1_if.rvalid), 32'd1);
        check("solo1_rdata1",  m1_if.rdata,       32'hA000_0014);
        check("idle_mem_rd",   32'(mem_rd),       32'd0);
        check("idle_addr_hold", 32'(mem_addr),    32'd20);

        // Write DEADBEEF to addr 5, then read it back the next cycle
        tick();
        drive(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        #2;
        check("wr_gnt0",   32'(m0_if.gnt), 32'd1);
        check("wr_mem_wr", 32'(mem_wr),    32'd1);
        check("wr_mem_rd", 32'(mem_rd),    32'd0);
        check("wr_addr",   32'(mem_addr),  32'd5);
        check("wr_wdata",  mem_wdata,      32'hDEAD_BEEF);
        tick();
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        #2;
        check("raw_gnt0",    32'(m0_if.gnt),    32'd1);
        check("raw_mem_rd",  32'(mem_rd),       32'd1);
        check("wr_no_rvalid", 32'(m0_if.rvalid), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("raw_rvalid0", 32'(m0_if.rvalid), 32'd1);
        check("raw_rdata0",  m0_if.rdata,       32'hDEAD_BEEF);
        check("raw_rvalid1", 32'(m1_if.rvalid), 32'd0);

        // Out-of-range read on port 1
        tick();
        drive(0, 0, 0, 0, 1, 0, 2048, 0);
        #2;
        check("oor_gnt1",   32'(m1_if.gnt), 32'd1);
        check("oor_mem_rd", 32'(mem_rd),    32'd0);
        check("oor_mem_wr", 32'(mem_wr),    32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("oor_err1",    32'(m1_if.err),    32'd1);
        check("oor_err0",    32'(m0_if.err),    32'd0);
        check("oor_rvalid1", 32'(m1_if.rvalid), 32'd0);
        tick();
        #2;
        check("oor_err1_end", 32'(m1_if.err), 32'd0);

        // Read issued, reset pulsed the following cycle: response is lost
        tick();
        drive(1, 0, 7, 0, 0, 0, 0, 0);
        #2;
        check("rstmid_gnt0", 32'(m0_if.gnt), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        check("rstmid_rvalid0", 32'(m0_if.rvalid), 32'd0);
        check("rstmid_addr",    32'(mem_addr),     32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("post_rst_rvalid0", 32'(m0_if.rvalid), 32'd0);
            check("post_rst_rdata0",  m0_if.rdata,       32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
